// File: rtl/regfile_wr_arb_pkg.sv
// Shared constants and FSM encoding for the regfile write-port arbiter.
package regfile_wr_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int ZERO_REG   = 0;
  localparam logic WRITE_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    ARB_EMPTY = 2'd0,
    ARB_HOLD  = 2'd1,
    ARB_FORCE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/regfile_wr_arb_if.sv
// WB/LU request side and regfile write side of the arbiter, bundled.
interface regfile_wr_arb_if #(
  parameter int ADDR_W = regfile_wr_arb_pkg::REG_ADDR_W,
  parameter int DATA_W = regfile_wr_arb_pkg::REG_DATA_W
);
  logic              wb_wen_i;
  logic [ADDR_W-1:0] wb_waddr_i;
  logic [DATA_W-1:0] wb_wdata_i;
  logic              lu_valid_i;
  logic              lu_ready_o;
  logic [ADDR_W-1:0] lu_waddr_i;
  logic [DATA_W-1:0] lu_wdata_i;
  logic              wen_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [DATA_W-1:0] wr_data_o;
  logic              stall_req_o;
  logic              buf_valid_o;
  logic [ADDR_W-1:0] buf_addr_o;
  logic [DATA_W-1:0] buf_data_o;

  modport master (
    output wb_wen_i, wb_waddr_i, wb_wdata_i, lu_valid_i, lu_waddr_i, lu_wdata_i,
    input  lu_ready_o, wen_o, wr_addr_o, wr_data_o, stall_req_o,
    input  buf_valid_o, buf_addr_o, buf_data_o
  );

  modport slave (
    input  wb_wen_i, wb_waddr_i, wb_wdata_i, lu_valid_i, lu_waddr_i, lu_wdata_i,
    output lu_ready_o, wen_o, wr_addr_o, wr_data_o, stall_req_o,
    output buf_valid_o, buf_addr_o, buf_data_o
  );
endinterface

// File: rtl/regfile_wr_arb_hold_buf.sv
// One-entry parking slot for an LU result that lost the write port.
module regfile_wr_arb_hold_buf #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              load,
  input  logic              drain,
  input  logic              cancel,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  logic              valid_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
    end else if (drain || cancel) begin
      valid_reg <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed while valid_reg is set.
  always_ff @(posedge clk) begin
    if (load) begin
      addr_reg <= load_addr;
      data_reg <= load_data;
    end
  end

  assign valid = valid_reg;
  assign addr  = addr_reg;
  assign data  = data_reg;

endmodule

// File: rtl/regfile_wr_arb.sv
// Regfile write-port arbiter: WB has priority, losing LU results are parked
// in a hold buffer, and prolonged starvation requests a pipeline stall.
module regfile_wr_arb
  import regfile_wr_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int DATA_W     = REG_DATA_W
) (
  input logic             clk,
  input logic             rstn,
  regfile_wr_arb_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  arb_state_e        state_reg, state_next;
  logic [CNT_W-1:0]  starve_cnt_reg, starve_cnt_next;
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic              lu_ready, lu_accept, lu_waw;
  logic              buf_load, buf_drain, buf_cancel;
  logic              wen;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign lu_ready  = !rstn && !buf_valid;
  assign lu_accept = bus.lu_valid_i && lu_ready;
  assign lu_waw    = bus.wb_wen_i && (bus.wb_waddr_i == bus.lu_waddr_i);
  // x0 results are accepted but never parked; a WAW-hit result is superseded by WB.
  assign buf_load   = lu_accept && bus.wb_wen_i && (bus.lu_waddr_i != ZERO_ADDR) && !lu_waw;
  assign buf_drain  = buf_valid && !bus.wb_wen_i;
  assign buf_cancel = buf_valid && bus.wb_wen_i && (bus.wb_waddr_i == buf_addr);

  regfile_wr_arb_hold_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_hold_buf (
    .clk       (clk),
    .srst      (rstn),
    .load      (buf_load),
    .drain     (buf_drain),
    .cancel    (buf_cancel),
    .load_addr (bus.lu_waddr_i),
    .load_data (bus.lu_wdata_i),
    .valid     (buf_valid),
    .addr      (buf_addr),
    .data      (buf_data)
  );

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_reg      <= ARB_EMPTY;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_EMPTY: if (buf_load) state_next = ARB_HOLD;
      ARB_HOLD: begin
        if (buf_drain || buf_cancel) begin
          state_next = ARB_EMPTY;
        end else if (bus.wb_wen_i && (starve_cnt_reg == CNT_W'(STARVE_MAX - 1))) begin
          state_next = ARB_FORCE;
        end
      end
      ARB_FORCE: if (buf_drain || buf_cancel) state_next = ARB_EMPTY;
      default:   state_next = ARB_EMPTY;
    endcase
  end

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (state_next != ARB_HOLD) begin
      starve_cnt_next = '0;
    end else if (state_reg == ARB_HOLD && bus.wb_wen_i &&
                 starve_cnt_reg != CNT_W'(STARVE_MAX)) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end
  end

  // Port mux: WB, then buffer, then LU pass-through; x0 never reaches the port.
  always_comb begin
    wen     = 1'b0;
    wr_addr = bus.wb_waddr_i;
    wr_data = bus.wb_wdata_i;
    if (!rstn) begin
      if (bus.wb_wen_i) begin
        wen = (bus.wb_waddr_i != ZERO_ADDR);
      end else if (buf_valid) begin
        wen     = WRITE_ENABLE;
        wr_addr = buf_addr;
        wr_data = buf_data;
      end else if (bus.lu_valid_i) begin
        wen     = (bus.lu_waddr_i != ZERO_ADDR);
        wr_addr = bus.lu_waddr_i;
        wr_data = bus.lu_wdata_i;
      end
    end
  end

  assign bus.lu_ready_o  = lu_ready;
  assign bus.wen_o       = wen;
  assign bus.wr_addr_o   = wr_addr;
  assign bus.wr_data_o   = wr_data;
  assign bus.stall_req_o = (state_reg == ARB_FORCE);
  assign bus.buf_valid_o = buf_valid;
  assign bus.buf_addr_o  = buf_addr;
  assign bus.buf_data_o  = buf_data;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Scenario bench for regfile_wr_arb: expected regfile writes are queued as
// stimulus is driven and matched in order against every wen_o pulse.
module tb_regfile_wr_arb;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SM = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  wr_t  exp_q[$];

  regfile_wr_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  regfile_wr_arb #(.STARVE_MAX(SM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard: each port write must match the oldest queued expectation.
  always @(negedge clk) begin
    wr_t e;
    if (bus.wen_o !== 1'b0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got r%0d=0x%08h, required no write", bus.wr_addr_o, bus.wr_data_o);
      end else begin
        e = exp_q.pop_front();
        if ({bus.wen_o, bus.wr_addr_o, bus.wr_data_o} !== {1'b1, e.addr, e.data}) begin
          n_err++;
          $display("FAIL port_write: got r%0d=0x%08h, required r%0d=0x%08h", bus.wr_addr_o, bus.wr_data_o, e.addr, e.data);
        end else begin
          $display("write r%0d=0x%08h ok", bus.wr_addr_o, bus.wr_data_o);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rstn) assert (!(bus.stall_req_o && bus.wb_wen_i)) else $error("protocol: WB write while stall requested");
  end

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld);
    bus.wb_wen_i   = we;
    bus.wb_waddr_i = wa;
    bus.wb_wdata_i = wd;
    bus.lu_valid_i = lv;
    bus.lu_waddr_i = la;
    bus.lu_wdata_i = ld;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    idle();
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    drive(1'b0, '0, '0, 1'b1, 5'd3, 32'h3);
    @(negedge clk);
    n_cmp++; if (bus.wen_o !== 1'b0) begin n_err++; $display("FAIL reset_wen: got %b, required 0", bus.wen_o); end
    n_cmp++; if (bus.lu_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_lu_ready: got %b, required 0", bus.lu_ready_o); end
    n_cmp++; if (bus.stall_req_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b, required 0", bus.stall_req_o); end
    n_cmp++; if (bus.buf_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_buf_valid: got %b, required 0", bus.buf_valid_o); end
    step();
    rstn = 1'b0;
    idle();
    @(negedge clk);
    n_cmp++; if (bus.lu_ready_o !== 1'b1) begin n_err++; $display("FAIL post_reset_lu_ready: got %b, required 1", bus.lu_ready_o); end
    step();
  endtask

  task automatic test_lu_passthrough();
    drive(1'b0, '0, '0, 1'b1, 5'd5, 32'h1234);
    push_exp(5'd5, 32'h1234);
    @(negedge clk);
    n_cmp++; if (bus.wen_o !== 1'b1 || bus.wr_addr_o !== 5'd5) begin n_err++; $display("FAIL lu_zero_latency: got wen=%b addr=%0d, required wen=1 addr=5", bus.wen_o, bus.wr_addr_o); end
    step();
    idle();
    @(negedge clk);
    n_cmp++; if (bus.buf_valid_o !== 1'b0) begin n_err++; $display("FAIL lu_pass_buf: got %b, required 0", bus.buf_valid_o); end
    step();
  endtask

  task automatic test_wb_priority();
    drive(1'b1, 5'd3, 32'hAA, 1'b1, 5'd7, 32'hBB);
    push_exp(5'd3, 32'hAA);
    push_exp(5'd7, 32'hBB);
    @(negedge clk);
    n_cmp++; if (bus.lu_ready_o !== 1'b1) begin n_err++; $display("FAIL prio_lu_ready: got %b, required 1", bus.lu_ready_o); end
    step();
    idle();
    @(negedge clk);
    n_cmp++; if ({bus.buf_valid_o, bus.buf_addr_o, bus.buf_data_o} !== {1'b1, 5'd7, 32'hBB}) begin n_err++; $display("FAIL prio_buf: got v=%b r%0d=0x%h, required v=1 r7=0xbb", bus.buf_valid_o, bus.buf_addr_o, bus.buf_data_o); end
    step();
    @(negedge clk);
    n_cmp++; if (bus.buf_valid_o !== 1'b0) begin n_err++; $display("FAIL prio_buf_drained: got %b, required 0", bus.buf_valid_o); end
    step();
  endtask

  task automatic test_starve();
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'h77);
    push_exp(5'd1, 32'h11);
    step();
    for (int i = 0; i < SM; i++) begin
      drive(1'b1, 5'(10 + i), 32'(256 + i), 1'b0, '0, '0);
      push_exp(5'(10 + i), 32'(256 + i));
      @(negedge clk);
      n_cmp++; if (bus.stall_req_o !== 1'b0) begin n_err++; $display("FAIL stall_early: cycle %0d got %b, required 0", i, bus.stall_req_o); end
      step();
    end
    push_exp(5'd7, 32'h77);
    idle();
    @(negedge clk);
    n_cmp++; if (bus.stall_req_o !== 1'b1) begin n_err++; $display("FAIL stall_asserted: got %b, required 1", bus.stall_req_o); end
    step();
    @(negedge clk);
    n_cmp++; if (bus.stall_req_o !== 1'b0 || bus.buf_valid_o !== 1'b0) begin n_err++; $display("FAIL stall_release: got stall=%b buf=%b, required 0 0", bus.stall_req_o, bus.buf_valid_o); end
    step();
  endtask

  task automatic test_waw();
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 32'h99);
    push_exp(5'd2, 32'h22);
    step();
    drive(1'b1, 5'd9, 32'h55, 1'b0, '0, '0);
    push_exp(5'd9, 32'h55);
    @(negedge clk);
    n_cmp++; if (bus.buf_valid_o !== 1'b1) begin n_err++; $display("FAIL waw_buf_held: got %b, required 1", bus.buf_valid_o); end
    step();
    idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.wen_o !== 1'b0 || bus.buf_valid_o !== 1'b0) begin n_err++; $display("FAIL waw_cancel: got wen=%b buf=%b, required 0 0", bus.wen_o, bus.buf_valid_o); end
      step();
    end
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h67);
    push_exp(5'd6, 32'h66);
    step();
    idle();
    @(negedge clk);
    n_cmp++; if (bus.wen_o !== 1'b0 || bus.buf_valid_o !== 1'b0) begin n_err++; $display("FAIL waw_capture: got wen=%b buf=%b, required 0 0", bus.wen_o, bus.buf_valid_o); end
    step();
  endtask

  task automatic test_x0();
    drive(1'b0, '0, '0, 1'b1, 5'd0, 32'hFF);
    @(negedge clk);
    n_cmp++; if (bus.lu_ready_o !== 1'b1 || bus.wen_o !== 1'b0) begin n_err++; $display("FAIL x0_drop: got ready=%b wen=%b, required 1 0", bus.lu_ready_o, bus.wen_o); end
    step();
    idle();
    @(negedge clk);
    n_cmp++; if (bus.buf_valid_o !== 1'b0) begin n_err++; $display("FAIL x0_buf: got %b, required 0", bus.buf_valid_o); end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, 1'b1, 5'(20 + i), 32'(176 + i));
      push_exp(5'(20 + i), 32'(176 + i));
      @(negedge clk);
      n_cmp++; if (bus.lu_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready: beat %0d got %b, required 1", i, bus.lu_ready_o); end
      step();
    end
    drive(1'b1, 5'd15, 32'hF5, 1'b1, 5'd16, 32'h16);
    push_exp(5'd15, 32'hF5);
    push_exp(5'd16, 32'h16);
    step();
    drive(1'b0, '0, '0, 1'b1, 5'd17, 32'h17);
    push_exp(5'd17, 32'h17);
    @(negedge clk);
    n_cmp++; if (bus.lu_ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_backpressure: got %b, required 0", bus.lu_ready_o); end
    step();
    @(negedge clk);
    n_cmp++; if (bus.lu_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_resume: got %b, required 1", bus.lu_ready_o); end
    step();
    idle();
    @(negedge clk);
    n_cmp++; if (bus.buf_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_buf_empty: got %b, required 0", bus.buf_valid_o); end
    step();
  endtask

  task automatic test_reset_force();
    drive(1'b1, 5'd1, 32'h21, 1'b1, 5'd4, 32'h44);
    push_exp(5'd1, 32'h21);
    step();
    for (int i = 0; i < SM; i++) begin
      drive(1'b1, 5'(10 + i), 32'(512 + i), 1'b0, '0, '0);
      push_exp(5'(10 + i), 32'(512 + i));
      step();
    end
    rstn = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 5'd12, 32'hC);
    @(negedge clk);
    n_cmp++; if (bus.stall_req_o !== 1'b1) begin n_err++; $display("FAIL force_reached: got %b, required 1", bus.stall_req_o); end
    n_cmp++; if (bus.wen_o !== 1'b0 || bus.lu_ready_o !== 1'b0) begin n_err++; $display("FAIL force_rst_gate: got wen=%b ready=%b, required 0 0", bus.wen_o, bus.lu_ready_o); end
    step();
    @(negedge clk);
    n_cmp++; if ({bus.buf_valid_o, bus.stall_req_o, bus.wen_o, bus.lu_ready_o} !== 4'b0000) begin n_err++; $display("FAIL force_rst_state: got buf=%b stall=%b wen=%b ready=%b, required 0000", bus.buf_valid_o, bus.stall_req_o, bus.wen_o, bus.lu_ready_o); end
    step();
    rstn = 1'b0;
    idle();
    @(negedge clk);
    n_cmp++; if (bus.wen_o !== 1'b0 || bus.lu_ready_o !== 1'b1) begin n_err++; $display("FAIL force_discard: got wen=%b ready=%b, required 0 1", bus.wen_o, bus.lu_ready_o); end
    step();
  endtask

  initial begin
    test_reset();
    test_lu_passthrough();
    test_wb_priority();
    test_starve();
    test_waw();
    test_x0();
    test_back_to_back();
    test_reset_force();
    repeat (2) step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
